modn_counter: RTL and testbench

MODN_COUNTER -- requirements
Module: modn_counter

---
 rtl/modn_counter.sv | 112 +++++++++++
 tb/tb_modn_counter.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/modn_counter.sv
// Modulo-N up/down/load counter with step size, a one-cycle wrap pulse,
// a sticky illegal-operation flag and a saturating wrap event counter.
module modn_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0] step,
  input  logic             clr_err,
  output logic [WIDTH-1:0] data_out,
  output logic             tc,
  output logic             wrap,
  output logic             err,
  output logic [7:0]       wrap_cnt
);

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_UP   = 2'b01,
    MODE_DOWN = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  localparam logic [WIDTH:0] MOD_X  = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0] LAST_X = (WIDTH+1)'(MODULUS - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  logic [7:0]       wrapCnt_q, wrapCnt_d;

  logic [WIDTH:0]   countX, stepX, dataX, sumX, nextX;
  logic             errSet;
  mode_e            modeOp;

  // One guard bit keeps sums and the borrow-corrected difference exact.
  assign countX = {1'b0, count_q};
  assign stepX  = {1'b0, step};
  assign dataX  = {1'b0, data_in};
  assign sumX   = countX + stepX;
  assign modeOp = mode_e'(mode);

  always_comb begin
    nextX  = countX;
    wrap_d = 1'b0;
    errSet = 1'b0;
    if (en) begin
      case (modeOp)
        MODE_UP: begin
          if (stepX >= MOD_X) begin
            errSet = 1'b1;
          end else if (sumX >= MOD_X) begin
            nextX  = sumX - MOD_X;
            wrap_d = 1'b1;
          end else begin
            nextX = sumX;
          end
        end
        MODE_DOWN: begin
          if (stepX >= MOD_X) begin
            errSet = 1'b1;
          end else if (countX >= stepX) begin
            nextX = countX - stepX;
          end else begin
            nextX  = countX + MOD_X - stepX;
            wrap_d = 1'b1;
          end
        end
        MODE_LOAD: begin
          if (dataX < MOD_X) begin
            nextX = dataX;
          end else begin
            errSet = 1'b1;
          end
        end
        default: begin
          nextX = countX;
        end
      endcase
    end
    count_d   = nextX[WIDTH-1:0];
    // A new error on the same edge as clr_err must win.
    err_d     = errSet | (err_q & ~clr_err);
    wrapCnt_d = (wrap_d && (wrapCnt_q != 8'hFF)) ? wrapCnt_q + 8'd1 : wrapCnt_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q   <= '0;
      wrap_q    <= 1'b0;
      err_q     <= 1'b0;
      wrapCnt_q <= 8'd0;
    end else begin
      count_q   <= count_d;
      wrap_q    <= wrap_d;
      err_q     <= err_d;
      wrapCnt_q <= wrapCnt_d;
    end
  end

  assign data_out = count_q;
  assign wrap     = wrap_q;
  assign err      = err_q;
  assign wrap_cnt = wrapCnt_q;
  assign tc       = en && (((modeOp == MODE_UP) && (countX == LAST_X)) ||
                           ((modeOp == MODE_DOWN) && (count_q == '0)));

endmodule

// File: tb/tb_modn_counter.sv
// Bench for modn_counter (WIDTH=4, MODULUS=12): constant vector table,
// saturation/reset sequence and random traffic against an arithmetic model.
module tb_modn_counter;

  localparam int WIDTH   = 4;
  localparam int MODULUS = 12;

  logic             clk = 1'b0;
  logic             reset, en, clr_err;
  logic [1:0]       mode;
  logic [WIDTH-1:0] data_in, step;
  logic [WIDTH-1:0] data_out;
  logic             tc, wrap, err;
  logic [7:0]       wrap_cnt;

  int assertCount = 0;
  int failCount   = 0;

  int mCount = 0, mWrap = 0, mErr = 0, mWrapCnt = 0;

  typedef struct {
    logic       r, e;
    logic [1:0] m;
    logic [3:0] d, s;
    logic       c;
    logic [3:0] expOut;
    logic       expTc, expWrap, expErr;
    logic [7:0] expWcnt;
  } vec_t;

  vec_t vecs[$];

  modn_counter #(.WIDTH(WIDTH), .MODULUS(MODULUS)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .data_in(data_in),
    .step(step), .clr_err(clr_err), .data_out(data_out), .tc(tc),
    .wrap(wrap), .err(err), .wrap_cnt(wrap_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int modelTc();
    if (!en) return 0;
    if (mode == 2'b01 && mCount == MODULUS - 1) return 1;
    if (mode == 2'b10 && mCount == 0) return 1;
    return 0;
  endfunction

  // Reference behaviour expressed as modular arithmetic on integers.
  task automatic modelEdge();
    int s, d, newErr;
    s      = int'(step);
    d      = int'(data_in);
    newErr = 0;
    if (!reset) begin
      mCount = 0; mWrap = 0; mErr = 0; mWrapCnt = 0;
      return;
    end
    mWrap = 0;
    if (en) begin
      case (mode)
        2'b01: if (s >= MODULUS) newErr = 1;
               else begin
                 mWrap  = (mCount + s >= MODULUS) ? 1 : 0;
                 mCount = (mCount + s) % MODULUS;
               end
        2'b10: if (s >= MODULUS) newErr = 1;
               else begin
                 mWrap  = (s > mCount) ? 1 : 0;
                 mCount = (mCount - s + MODULUS) % MODULUS;
               end
        2'b11: if (d < MODULUS) mCount = d; else newErr = 1;
        default: ;
      endcase
    end
    if (mWrap == 1 && mWrapCnt < 255) mWrapCnt++;
    if (newErr == 1) mErr = 1;
    else if (clr_err) mErr = 0;
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic [1:0] m,
                               input logic [3:0] d, input logic [3:0] s, input logic c,
                               output logic tcSeen);
    @(negedge clk);
    reset = r; en = e; mode = m; data_in = d; step = s; clr_err = c;
    #1;
    tcSeen = tc;
    checkOutput("tc model", tc, modelTc());
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput("data_out model", data_out, mCount);
    checkOutput("wrap model", wrap, mWrap);
    checkOutput("err model", err, mErr);
    checkOutput("wrap_cnt model", wrap_cnt, mWrapCnt);
  endtask

  initial begin
    logic tcSeen;
    reset = 1'b0; en = 1'b0; mode = 2'b00; data_in = '0; step = '0; clr_err = 1'b0;

    //              r  e  m      d   s  c   out tc wr er wcnt
    vecs.push_back('{0, 0, 2'd0, 0,  0, 0,  0,  0, 0, 0, 0});
    vecs.push_back('{1, 1, 2'd3, 9,  0, 0,  9,  0, 0, 0, 0});
    vecs.push_back('{1, 1, 2'd1, 0,  1, 0,  10, 0, 0, 0, 0});
    vecs.push_back('{1, 1, 2'd1, 0,  1, 0,  11, 0, 0, 0, 0});
    vecs.push_back('{1, 1, 2'd1, 0,  1, 0,  0,  1, 1, 0, 1});
    vecs.push_back('{1, 1, 2'd0, 0,  1, 0,  0,  0, 0, 0, 1});
    vecs.push_back('{1, 1, 2'd3, 2,  0, 0,  2,  0, 0, 0, 1});
    vecs.push_back('{1, 1, 2'd2, 0,  5, 0,  9,  0, 1, 0, 2});
    vecs.push_back('{1, 1, 2'd2, 0,  5, 0,  4,  0, 0, 0, 2});
    vecs.push_back('{1, 1, 2'd3, 13, 0, 0,  4,  0, 0, 1, 2});
    vecs.push_back('{1, 1, 2'd0, 0,  0, 1,  4,  0, 0, 0, 2});
    vecs.push_back('{1, 1, 2'd3, 15, 0, 1,  4,  0, 0, 1, 2});
    vecs.push_back('{1, 1, 2'd0, 0,  0, 1,  4,  0, 0, 0, 2});
    vecs.push_back('{1, 1, 2'd1, 0,  12,0,  4,  0, 0, 1, 2});
    vecs.push_back('{1, 0, 2'd1, 0,  1, 0,  4,  0, 0, 1, 2});
    vecs.push_back('{1, 0, 2'd1, 0,  1, 1,  4,  0, 0, 0, 2});
    vecs.push_back('{1, 1, 2'd1, 0,  0, 0,  4,  0, 0, 0, 2});
    vecs.push_back('{1, 1, 2'd2, 0,  0, 0,  4,  0, 0, 0, 2});
    vecs.push_back('{1, 1, 2'd3, 0,  0, 0,  0,  0, 0, 0, 2});
    vecs.push_back('{1, 1, 2'd2, 0,  1, 0,  11, 1, 1, 0, 3});
    vecs.push_back('{1, 1, 2'd3, 14, 0, 0,  11, 0, 0, 1, 3});
    vecs.push_back('{0, 1, 2'd1, 0,  3, 0,  0,  1, 0, 0, 0});
    vecs.push_back('{1, 1, 2'd1, 0,  3, 0,  3,  0, 0, 0, 0});

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].r, vecs[i].e, vecs[i].m, vecs[i].d, vecs[i].s, vecs[i].c, tcSeen);
      checkOutput($sformatf("vec%0d tc", i), tcSeen, vecs[i].expTc);
      checkOutput($sformatf("vec%0d data_out", i), data_out, vecs[i].expOut);
      checkOutput($sformatf("vec%0d wrap", i), wrap, vecs[i].expWrap);
      checkOutput($sformatf("vec%0d err", i), err, vecs[i].expErr);
      checkOutput($sformatf("vec%0d wrap_cnt", i), wrap_cnt, vecs[i].expWcnt);
    end

    // 300 up-steps of 11 from zero wrap 275 times, so wrap_cnt must pin at 255.
    applyStimulus(1'b0, 1'b0, 2'd0, 4'd0, 4'd0, 1'b0, tcSeen);
    for (int i = 0; i < 300; i++)
      applyStimulus(1'b1, 1'b1, 2'd1, 4'd0, 4'd11, 1'b0, tcSeen);
    checkOutput("saturated wrap_cnt", wrap_cnt, 8'd255);
    checkOutput("count after 300", data_out, 4'd0);
    for (int i = 0; i < 12 && mCount != 7; i++)
      applyStimulus(1'b1, 1'b1, 2'd1, 4'd0, 4'd11, 1'b0, tcSeen);
    checkOutput("reached 7", data_out, 4'd7);
    applyStimulus(1'b0, 1'b1, 2'd1, 4'd0, 4'd11, 1'b0, tcSeen);
    checkOutput("mid-run reset data_out", data_out, 4'd0);
    checkOutput("mid-run reset wrap_cnt", wrap_cnt, 8'd0);
    applyStimulus(1'b1, 1'b1, 2'd1, 4'd0, 4'd1, 1'b0, tcSeen);
    checkOutput("resume after reset", data_out, 4'd1);

    for (int i = 0; i < 300; i++) begin
      applyStimulus(($urandom_range(0, 24) != 0), ($urandom_range(0, 7) != 0),
                    2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                    4'($urandom_range(0, 15)), ($urandom_range(0, 5) == 0), tcSeen);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
